debouncer_botones: RTL and testbench

DEBOUNCER_BOTONES -- requirements
Module: debouncer_botones

---
 rtl/debouncer_botones.sv | 135 +++++++++++++
 tb/tb_debouncer_botones.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/debouncer_botones.sv
// Per-button push-button debouncer: two-flop synchronizer, 4-state stability FSM,
// registered level and press strobe. Define DEBOUNCE_ONEHOT_EN to suppress coincident strobes.
module debouncer_botones #(
    parameter int N_BTN    = 3,
    parameter int NB_CNT   = 20,
    parameter int N_STABLE = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] i_btn,
    output logic [N_BTN-1:0] o_level,
    output logic [N_BTN-1:0] o_pulse
);

    typedef enum logic [1:0] {
        LOW    = 2'd0,
        WAIT_H = 2'd1,
        HIGH   = 2'd2,
        WAIT_L = 2'd3
    } state_t;

    localparam logic [NB_CNT-1:0] CNT_ONE  = NB_CNT'(1);
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(N_STABLE - 1);

    logic [N_BTN-1:0] sync1_reg;
    logic [N_BTN-1:0] sync2_reg;
    logic [N_BTN-1:0] level_next;
    logic [N_BTN-1:0] pulse_next;
    logic [N_BTN-1:0] pulse_filt;
    logic [N_BTN-1:0] level_reg;
    logic [N_BTN-1:0] pulse_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= i_btn;
            sync2_reg <= sync1_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_BTN; gi++) begin : g_btn
            state_t            state_reg;
            state_t            state_next;
            logic [NB_CNT-1:0] cnt_reg;
            logic [NB_CNT-1:0] cnt_next;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    state_reg <= LOW;
                    cnt_reg   <= '0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                end
            end

            // Any sample disagreeing with the pending level aborts the qualification window.
            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                case (state_reg)
                    LOW: begin
                        if (sync2_reg[gi]) begin
                            state_next = WAIT_H;
                            cnt_next   = CNT_ONE;
                        end
                    end
                    WAIT_H: begin
                        if (!sync2_reg[gi]) begin
                            state_next = LOW;
                            cnt_next   = '0;
                        end else if (cnt_reg == CNT_LAST) begin
                            state_next = HIGH;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_reg + CNT_ONE;
                        end
                    end
                    HIGH: begin
                        if (!sync2_reg[gi]) begin
                            state_next = WAIT_L;
                            cnt_next   = CNT_ONE;
                        end
                    end
                    WAIT_L: begin
                        if (sync2_reg[gi]) begin
                            state_next = HIGH;
                            cnt_next   = '0;
                        end else if (cnt_reg == CNT_LAST) begin
                            state_next = LOW;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_reg + CNT_ONE;
                        end
                    end
                    default: begin
                        state_next = LOW;
                        cnt_next   = '0;
                    end
                endcase
            end

            // Outputs are decoded from the next state so they register alongside it.
            assign level_next[gi] = (state_next == HIGH) || (state_next == WAIT_L);
            assign pulse_next[gi] = (state_reg == WAIT_H) && (state_next == HIGH);
        end
    endgenerate

`ifdef DEBOUNCE_ONEHOT_EN
    logic multi_pulse;
    // More than one bit set <=> clearing the lowest set bit leaves something behind.
    assign multi_pulse = |(pulse_next & (pulse_next - N_BTN'(1)));
    assign pulse_filt  = multi_pulse ? '0 : pulse_next;
`else
    assign pulse_filt = pulse_next;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_reg <= '0;
            pulse_reg <= '0;
        end else begin
            level_reg <= level_next;
            pulse_reg <= pulse_filt;
        end
    end

    assign o_level = level_reg;
    assign o_pulse = pulse_reg;

endmodule

// File: tb/tb_debouncer_botones.sv
// Scoreboard bench for debouncer_botones with N_STABLE=4: stimulus schedules expected
// (level, pulse) pairs per edge count; the monitor checks them and flags any unscheduled pulse.
module tb_debouncer_botones;

    localparam int N_BTN    = 3;
    localparam int NB_CNT   = 20;
    localparam int N_STABLE = 4;

`ifdef DEBOUNCE_ONEHOT_EN
    localparam logic [2:0] PLS_111 = 3'b000;
    localparam logic [2:0] PLS_011 = 3'b000;
`else
    localparam logic [2:0] PLS_111 = 3'b111;
    localparam logic [2:0] PLS_011 = 3'b011;
`endif

    typedef struct {
        int         cyc;
        logic [2:0] lvl;
        logic [2:0] pls;
        string      name;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic [N_BTN-1:0] i_btn;
    logic [N_BTN-1:0] o_level;
    logic [N_BTN-1:0] o_pulse;

    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    bit   mon_found;
    int   mon_idx;
    exp_t mon_e;

    debouncer_botones #(
        .N_BTN   (N_BTN),
        .NB_CNT  (NB_CNT),
        .N_STABLE(N_STABLE)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_btn  (i_btn),
        .o_level(o_level),
        .o_pulse(o_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: at each falling edge, cyc equals the number of rising edges so far.
    always @(negedge clk) begin
        mon_found = 1'b0;
        mon_idx   = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (!mon_found && exp_q[i].cyc == cyc) begin
                mon_found = 1'b1;
                mon_idx   = i;
            end
        end
        if (mon_found) begin
            mon_e = exp_q[mon_idx];
            exp_q.delete(mon_idx);
            n_checks++;
            if (o_level !== mon_e.lvl || o_pulse !== mon_e.pls) begin
                n_fail++;
                $display("FAIL %s edge=%0d level=%b pulse=%b required level=%b pulse=%b",
                         mon_e.name, cyc, o_level, o_pulse, mon_e.lvl, mon_e.pls);
            end else begin
                $display("ok   %s edge=%0d level=%b pulse=%b", mon_e.name, cyc, o_level, o_pulse);
            end
        end else begin
            n_checks++;
            if (o_pulse !== 3'b000) begin
                n_fail++;
                $display("FAIL spurious_pulse edge=%0d pulse=%b required pulse=000", cyc, o_pulse);
            end
        end
    end

    task automatic expect_at(input int t, input logic [2:0] lvl, input logic [2:0] pls,
                             input string name);
        exp_t e;
        e.cyc  = t;
        e.lvl  = lvl;
        e.pls  = pls;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic at(input int t);
        do @(negedge clk); while (cyc < t);
    endtask

    initial begin
        rst_n = 1'b0;
        i_btn = 3'b111;

        // Reset held 3 edges with all buttons pressed, then treated as a fresh press.
        expect_at(1, 3'b000, 3'b000, "reset_e1");
        expect_at(2, 3'b000, 3'b000, "reset_e2");
        expect_at(3, 3'b000, 3'b000, "reset_e3");
        expect_at(8, 3'b000, 3'b000, "post_reset_pre");
        expect_at(9, 3'b111, PLS_111, "post_reset_press");
        expect_at(10, 3'b111, 3'b000, "post_reset_after");
        at(3);
        rst_n = 1'b1;

        // Release all: level drops N_STABLE+2 edges later.
        at(12);
        i_btn = 3'b000;
        expect_at(17, 3'b111, 3'b000, "release_pre");
        expect_at(18, 3'b000, 3'b000, "release_all");

        // Clean press of button 0 held for 20 cycles.
        at(22);
        i_btn = 3'b001;
        expect_at(27, 3'b000, 3'b000, "clean_pre");
        expect_at(28, 3'b001, 3'b001, "clean_press");
        expect_at(29, 3'b001, 3'b000, "clean_pulse_end");
        at(42);
        i_btn = 3'b000;
        expect_at(47, 3'b001, 3'b000, "clean_rel_pre");
        expect_at(48, 3'b000, 3'b000, "clean_release");

        // Bouncing button 1: 1,0,1,1,0,1 then stable.
        at(52); i_btn = 3'b010;
        at(53); i_btn = 3'b000;
        at(54); i_btn = 3'b010;
        at(55); i_btn = 3'b010;
        at(56); i_btn = 3'b000;
        at(57); i_btn = 3'b010;
        expect_at(62, 3'b000, 3'b000, "bounce_pre");
        expect_at(63, 3'b010, 3'b010, "bounce_press");
        expect_at(64, 3'b010, 3'b000, "bounce_pulse_end");
        at(67);
        i_btn = 3'b000;
        expect_at(72, 3'b010, 3'b000, "bounce_rel_pre");
        expect_at(73, 3'b000, 3'b000, "bounce_release");

        // Button 2 pressed, then a 2-cycle release glitch that must not drop the level.
        at(80);
        i_btn = 3'b100;
        expect_at(86, 3'b100, 3'b100, "glitch_press");
        for (int t = 87; t <= 100; t++) expect_at(t, 3'b100, 3'b000, "glitch_hold");
        at(90); i_btn = 3'b000;
        at(92); i_btn = 3'b100;
        at(100);
        i_btn = 3'b000;
        expect_at(105, 3'b100, 3'b000, "glitch_rel_pre");
        expect_at(106, 3'b000, 3'b000, "glitch_release");

        // Simultaneous press of buttons 0 and 1.
        at(110);
        i_btn = 3'b011;
        expect_at(115, 3'b000, 3'b000, "simul_pre");
        expect_at(116, 3'b011, PLS_011, "simul_press");
        expect_at(117, 3'b011, 3'b000, "simul_after");
        at(120);
        i_btn = 3'b000;
        expect_at(125, 3'b011, 3'b000, "simul_rel_pre");
        expect_at(126, 3'b000, 3'b000, "simul_release");

        // One-cycle reset while button 0 counter is at 2.
        at(130);
        i_btn = 3'b001;
        at(134);
        rst_n = 1'b0;
        expect_at(135, 3'b000, 3'b000, "midcount_reset");
        at(135);
        rst_n = 1'b1;
        expect_at(140, 3'b000, 3'b000, "midcount_pre");
        expect_at(141, 3'b001, 3'b001, "midcount_press");
        expect_at(142, 3'b001, 3'b000, "midcount_after");
        at(150);
        i_btn = 3'b000;
        expect_at(155, 3'b001, 3'b000, "midcount_rel_pre");
        expect_at(156, 3'b000, 3'b000, "midcount_release");

        // Reset on the edge that would have produced the pulse; no residual strobe.
        at(170);
        i_btn = 3'b100;
        at(175);
        rst_n = 1'b0;
        expect_at(176, 3'b000, 3'b000, "midpulse_reset");
        at(176);
        rst_n = 1'b1;
        expect_at(181, 3'b000, 3'b000, "midpulse_pre");
        expect_at(182, 3'b100, 3'b100, "midpulse_press");
        at(190);
        i_btn = 3'b000;
        expect_at(196, 3'b000, 3'b000, "midpulse_release");

        at(205);
        while (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL missed_check %s edge=%0d never evaluated", exp_q[0].name, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
